doodle_motion: RTL and testbench
================================

# doodle_motion

Parameterised jump/fall controller for the doodle character, driven by the frame tick. It tracks the doodle's vertical screen position and the height of the current jump. It turns platform-landing events from the collision logic into new jumps, signals screen scroll when the doodle reaches the top band, and keeps a running score and a high score. It sits between the game-control top level, which supplies start/ack and jump height, and the renderer/platform logic, which consumes Y, Scroll and the score values.

## Interface
- W, 10: width of Y, Curr, J, Jin.
- SW, 16: width of Score and HiScore.
- STEP, 2: pixels moved per tick; must be ≥1.
- JUMP_DEF, 100: jump height used when Jin==0; also the reset value of J.
- Y_START, 400: spawn row.
- Y_TOP, 120: highest row the doodle may occupy; above this the world scrolls instead.
- Y_BOTTOM, 479: death row. Required ordering: Y_TOP < Y_START < Y_BOTTOM < 2^W.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Tick  in  1  one-cycle frame-tick strobe; motion advances only on ticks.
- Start  in  1  begin game (sampled in I).
- Ack  in  1  acknowledge game over (sampled in DONE).
- Land  in  1  doodle feet overlap a platform this cycle (from collision logic).
- Jin  in  W  requested jump height in pixels; 0 selects JUMP_DEF.
- J  out  W  latched jump height.
- Curr  out  W  distance climbed in the current jump.
- Y  out  W  doodle row (0 = top of screen).
- Score  out  SW  current game score.
- HiScore  out  SW  best score since reset.
- Scroll  out  1  one-cycle pulse: world scrolls down by STEP this tick.
- q_I, q_Up, q_Down, q_Done  out  1 each  one-hot state.

## Operation
- The state register is one-hot, with states I, UP, DOWN, DONE. Any illegal encoding returns to I on the next edge.
- I:
  - On Start: J←(Jin==0 ? JUMP_DEF : Jin), Curr←0, Score←0, Y←Y_START, go to UP.
  - Tick is not required for this transition.
- UP (acts only when Tick=1):
  - If Curr ≥ J: go to DOWN; Y and Curr hold.
  - Else let d = min(STEP, J−Curr). Then Curr←Curr+d and Score←Score+d, with Score saturating at 2^SW−1.
  - If Y−d ≥ Y_TOP: Y←Y−d.
  - Else: Y←Y_TOP and Scroll=1 for this cycle.
  - Land is ignored in UP.
- DOWN (acts only when Tick=1), in priority order:
  1. Land=1: Curr←0, go to UP. Y holds and Score is unchanged.
  2. Y+STEP ≥ Y_BOTTOM: Y←Y_BOTTOM, go to DONE. In the same edge, HiScore←Score if Score > HiScore.
  3. Otherwise: Y←Y+STEP and Curr←Curr−STEP, clamping Curr at 0.
- DONE: all outputs hold. On Ack go to I; Score, HiScore and Y keep their values until the next Start.
- Arithmetic:
  - Y/Curr sums are computed W+1 bits wide before compare, so there is no wrap.
  - Score is computed SW+1 bits wide, then saturated.
- HiScore is cleared only by Reset.

## Timing
- Reset value of every output:
  - q_I=1, all other q_*=0.
  - Y=Y_START, Curr=0, J=JUMP_DEF, Score=0, HiScore=0, Scroll=0.
- Reset asserted mid-game aborts immediately, asynchronously, to the values above.
- All outputs are registered. A Tick sampled at edge n is reflected in the outputs after edge n.
- Scroll is high for exactly the cycle after the tick edge on which the clamp occurred, and low on non-tick cycles.
- Latency:
  - Start→UP: 1 edge.
  - Land→UP: 1 edge on the tick cycle.
  - Ack→I: 1 edge.
- Land or Start/Ack must coincide with Tick only where stated above. Land without Tick is ignored.
- Land and the bottom condition on the same tick: Land wins, so the game continues.

## Test plan
- Reset: drive Reset=0 for 3 cycles, then release → q_I=1, Y=400, J=100, Curr=0, Score=0, HiScore=0, Scroll=0.
- Jump: Jin=10, pulse Start, then 5 ticks → Curr 2,4,6,8,10; Y 398…390; Score=10. The 6th tick → q_Down=1 with Y=390 held. A Jin=9 run gives a final step of 1 (Curr=9, Score=9).
- Landing: in DOWN at Y=394, assert Land with Tick → q_Up=1, Curr=0, Y=394. Land asserted without Tick → no change. Land on the same tick as bottom → UP.
- Death: fall from Y=474 with no Land → ticks give Y 476, 478, then Y=479 and q_Done=1, HiScore=Score. Ack → I. A second game with a lower score leaves HiScore unchanged.
- Scroll: Y_START=124, Jin=20 → after 2 ticks Y=120. The next 8 ticks each give Scroll=1 for one cycle, Y stays 120, and Score keeps incrementing to 20.
- Mid-game reset: assert Reset during UP with Curr=6 → outputs go to reset values before the next Clk edge. HiScore=0.

Source files
------------

// File: rtl/doodle_motion.sv
// doodle_motion: frame-tick driven jump/fall controller for the doodle.
// Tracks row, jump progress, scroll pulses, score and high score.
module doodle_motion #(
    parameter int W        = 10,
    parameter int SW       = 16,
    parameter int STEP     = 2,
    parameter int JUMP_DEF = 100,
    parameter int Y_START  = 400,
    parameter int Y_TOP    = 120,
    parameter int Y_BOTTOM = 479
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Tick,
    input  logic          Start,
    input  logic          Ack,
    input  logic          Land,
    input  logic [W-1:0]  Jin,
    output logic [W-1:0]  J,
    output logic [W-1:0]  Curr,
    output logic [W-1:0]  Y,
    output logic [SW-1:0] Score,
    output logic [SW-1:0] HiScore,
    output logic          Scroll,
    output logic          q_I,
    output logic          q_Up,
    output logic          q_Down,
    output logic          q_Done
);

    localparam logic [3:0] S_I    = 4'b0001;
    localparam logic [3:0] S_UP   = 4'b0010;
    localparam logic [3:0] S_DOWN = 4'b0100;
    localparam logic [3:0] S_DONE = 4'b1000;

    localparam logic [W-1:0] STEP_W  = W'(STEP);
    localparam logic [W-1:0] JDEF_W  = W'(JUMP_DEF);
    localparam logic [W-1:0] YST_W   = W'(Y_START);
    localparam logic [W-1:0] YTOP_W  = W'(Y_TOP);
    localparam logic [W-1:0] YBOT_W  = W'(Y_BOTTOM);
    localparam logic [W:0]   STEP_X  = (W+1)'(STEP);
    localparam logic [W:0]   YTOP_X  = (W+1)'(Y_TOP);
    localparam logic [W:0]   YBOT_X  = (W+1)'(Y_BOTTOM);
    localparam logic [SW-1:0] SMAX   = '1;

    logic [3:0]    state_q, state_d;
    logic [W-1:0]  j_q, j_d;
    logic [W-1:0]  curr_q, curr_d;
    logic [W-1:0]  y_q, y_d;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] hi_q, hi_d;
    logic          scroll_q, scroll_d;

    logic [W-1:0]  rem;
    logic [W-1:0]  dstep;
    logic          jump_done;
    logic          up_fits;
    logic          fall_bottom;
    logic [W:0]    down_sum;
    logic [SW:0]   score_sum;

    // Shared arithmetic, widened by one bit so compares never wrap
    always_comb begin
        jump_done   = (curr_q >= j_q);
        rem         = j_q - curr_q;
        dstep       = (rem < STEP_W) ? rem : STEP_W;
        up_fits     = ({1'b0, y_q} >= (YTOP_X + {1'b0, dstep}));
        down_sum    = {1'b0, y_q} + STEP_X;
        fall_bottom = (down_sum >= YBOT_X);
        score_sum   = {1'b0, score_q} + (SW+1)'(dstep);
    end

    // State register and datapath registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_I;
            j_q      <= JDEF_W;
            curr_q   <= '0;
            y_q      <= YST_W;
            score_q  <= '0;
            hi_q     <= '0;
            scroll_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            curr_q   <= curr_d;
            y_q      <= y_d;
            score_q  <= score_d;
            hi_q     <= hi_d;
            scroll_q <= scroll_d;
        end
    end

    // Next-state logic; illegal encodings fall back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_I: begin
                if (Start) state_d = S_UP;
            end
            S_UP: begin
                if (Tick && jump_done) state_d = S_DOWN;
            end
            S_DOWN: begin
                if (Tick) begin
                    if (Land)             state_d = S_UP;
                    else if (fall_bottom) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (Ack) state_d = S_I;
            end
            default: state_d = S_I;
        endcase
    end

    // Datapath next values per state
    always_comb begin
        j_d      = j_q;
        curr_d   = curr_q;
        y_d      = y_q;
        score_d  = score_q;
        hi_d     = hi_q;
        scroll_d = 1'b0;
        case (state_q)
            S_I: begin
                if (Start) begin
                    j_d     = (Jin == '0) ? JDEF_W : Jin;
                    curr_d  = '0;
                    score_d = '0;
                    y_d     = YST_W;
                end
            end
            S_UP: begin
                if (Tick && !jump_done) begin
                    curr_d  = curr_q + dstep;
                    score_d = score_sum[SW] ? SMAX : score_sum[SW-1:0];
                    if (up_fits) begin
                        y_d = y_q - dstep;
                    end else begin
                        y_d      = YTOP_W;
                        scroll_d = 1'b1;
                    end
                end
            end
            S_DOWN: begin
                if (Tick) begin
                    if (Land) begin
                        curr_d = '0;
                    end else if (fall_bottom) begin
                        y_d = YBOT_W;
                        if (score_q > hi_q) hi_d = score_q;
                    end else begin
                        y_d    = down_sum[W-1:0];
                        curr_d = (curr_q >= STEP_W) ? curr_q - STEP_W : '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_comb begin
        J       = j_q;
        Curr    = curr_q;
        Y       = y_q;
        Score   = score_q;
        HiScore = hi_q;
        Scroll  = scroll_q;
        q_I     = state_q[0];
        q_Up    = state_q[1];
        q_Down  = state_q[2];
        q_Done  = state_q[3];
    end

endmodule

// File: tb/tb_doodle_motion.sv
// tb_doodle_motion: directed bench for doodle_motion.
// Second instance uses a low spawn row to reach the scroll band.
module tb_doodle_motion;

    logic        Clk, Reset, Tick, Start, Ack, Land;
    logic [9:0]  Jin;
    logic [9:0]  J, Curr, Y, J2, Curr2, Y2;
    logic [15:0] Score, HiScore, Score2, HiScore2;
    logic        Scroll, q_I, q_Up, q_Down, q_Done;
    logic        Scroll2, q_I2, q_Up2, q_Down2, q_Done2;
    int checks = 0;
    int failures = 0;

    doodle_motion dut (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start),
        .Ack(Ack), .Land(Land), .Jin(Jin), .J(J), .Curr(Curr),
        .Y(Y), .Score(Score), .HiScore(HiScore), .Scroll(Scroll),
        .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done)
    );

    doodle_motion #(.Y_START(124)) dut2 (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start),
        .Ack(Ack), .Land(Land), .Jin(Jin), .J(J2), .Curr(Curr2),
        .Y(Y2), .Score(Score2), .HiScore(HiScore2), .Scroll(Scroll2),
        .q_I(q_I2), .q_Up(q_Up2), .q_Down(q_Down2), .q_Done(q_Done2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic do_tick(input logic land);
        @(negedge Clk);
        Tick = 1'b1;
        Land = land;
        @(negedge Clk);
        Tick = 1'b0;
        Land = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] jin);
        @(negedge Clk);
        Jin = jin;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({q_I, q_Up, q_Down, q_Done} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=1000", {q_I, q_Up, q_Down, q_Done});
        end
        checks++;
        if (Y !== 10'd400 || J !== 10'd100 || Curr !== 10'd0) begin
            failures++;
            $display("FAIL reset_pos got Y=%0d J=%0d Curr=%0d exp 400/100/0", Y, J, Curr);
        end
        checks++;
        if (Score !== 16'd0 || HiScore !== 16'd0 || Scroll !== 1'b0) begin
            failures++;
            $display("FAIL reset_score got S=%0d H=%0d Sc=%b exp 0/0/0", Score, HiScore, Scroll);
        end
    endtask

    task automatic test_scroll;
        do_start(10'd20);
        do_tick(1'b0);
        do_tick(1'b0);
        checks++;
        if (Y2 !== 10'd120 || Scroll2 !== 1'b0) begin
            failures++;
            $display("FAIL scroll_reach got Y=%0d Sc=%b exp 120/0", Y2, Scroll2);
        end
        for (int i = 0; i < 8; i++) begin
            do_tick(1'b0);
            checks++;
            if (Scroll2 !== 1'b1 || Y2 !== 10'd120 || Score2 !== 16'(6 + 2 * i)) begin
                failures++;
                $display("FAIL scroll_tick%0d got Sc=%b Y=%0d S=%0d exp 1/120/%0d",
                         i, Scroll2, Y2, Score2, 6 + 2 * i);
            end
        end
        @(negedge Clk);
        checks++;
        if (Scroll2 !== 1'b0 || Score2 !== 16'd20) begin
            failures++;
            $display("FAIL scroll_idle got Sc=%b S=%0d exp 0/20", Scroll2, Score2);
        end
    endtask

    task automatic test_jump;
        do_start(10'd10);
        checks++;
        if (q_Up !== 1'b1 || Y !== 10'd400 || Curr !== 10'd0 || J !== 10'd10) begin
            failures++;
            $display("FAIL jump_start got Up=%b Y=%0d C=%0d J=%0d", q_Up, Y, Curr, J);
        end
        for (int i = 1; i <= 5; i++) begin
            do_tick(1'b0);
            checks++;
            if (Curr !== 10'(2 * i) || Y !== 10'(400 - 2 * i)) begin
                failures++;
                $display("FAIL jump_tick%0d got C=%0d Y=%0d exp %0d/%0d",
                         i, Curr, Y, 2 * i, 400 - 2 * i);
            end
        end
        checks++;
        if (Score !== 16'd10) begin
            failures++;
            $display("FAIL jump_score got=%0d exp=10", Score);
        end
        do_tick(1'b0);
        checks++;
        if (q_Down !== 1'b1 || Y !== 10'd390 || Curr !== 10'd10) begin
            failures++;
            $display("FAIL jump_apex got Dn=%b Y=%0d C=%0d exp 1/390/10", q_Down, Y, Curr);
        end
    endtask

    task automatic test_landing;
        do_tick(1'b0);
        do_tick(1'b0);
        checks++;
        if (Y !== 10'd394 || Curr !== 10'd6) begin
            failures++;
            $display("FAIL fall_pos got Y=%0d C=%0d exp 394/6", Y, Curr);
        end
        @(negedge Clk);
        Land = 1'b1;
        @(negedge Clk);
        Land = 1'b0;
        checks++;
        if (q_Down !== 1'b1 || Y !== 10'd394 || Curr !== 10'd6) begin
            failures++;
            $display("FAIL land_notick got Dn=%b Y=%0d C=%0d exp 1/394/6", q_Down, Y, Curr);
        end
        do_tick(1'b1);
        checks++;
        if (q_Up !== 1'b1 || Y !== 10'd394 || Curr !== 10'd0 || Score !== 16'd10) begin
            failures++;
            $display("FAIL land_tick got Up=%b Y=%0d C=%0d S=%0d exp 1/394/0/10",
                     q_Up, Y, Curr, Score);
        end
        repeat (6) do_tick(1'b0);
        for (int k = 0; k < 100 && Y !== 10'd478; k++) do_tick(1'b0);
        checks++;
        if (Y !== 10'd478 || q_Down !== 1'b1 || Curr !== 10'd0) begin
            failures++;
            $display("FAIL fall_478 got Y=%0d Dn=%b C=%0d exp 478/1/0", Y, q_Down, Curr);
        end
        do_tick(1'b1);
        checks++;
        if (q_Up !== 1'b1 || Y !== 10'd478 || q_Done !== 1'b0) begin
            failures++;
            $display("FAIL land_bottom got Up=%b Y=%0d Done=%b exp 1/478/0", q_Up, Y, q_Done);
        end
    endtask

    task automatic test_death;
        repeat (6) do_tick(1'b0);
        checks++;
        if (q_Down !== 1'b1 || Y !== 10'd468 || Score !== 16'd30) begin
            failures++;
            $display("FAIL death_apex got Dn=%b Y=%0d S=%0d exp 1/468/30", q_Down, Y, Score);
        end
        for (int k = 0; k < 10 && Y !== 10'd474; k++) do_tick(1'b0);
        do_tick(1'b0);
        checks++;
        if (Y !== 10'd476) begin
            failures++;
            $display("FAIL death_476 got Y=%0d exp 476", Y);
        end
        do_tick(1'b0);
        checks++;
        if (Y !== 10'd478 || q_Down !== 1'b1) begin
            failures++;
            $display("FAIL death_478 got Y=%0d Dn=%b exp 478/1", Y, q_Down);
        end
        do_tick(1'b0);
        checks++;
        if (Y !== 10'd479 || q_Done !== 1'b1 || HiScore !== 16'd30) begin
            failures++;
            $display("FAIL death_done got Y=%0d Done=%b H=%0d exp 479/1/30", Y, q_Done, HiScore);
        end
        do_tick(1'b1);
        checks++;
        if (q_Done !== 1'b1 || Y !== 10'd479 || Score !== 16'd30) begin
            failures++;
            $display("FAIL done_hold got Done=%b Y=%0d S=%0d exp 1/479/30", q_Done, Y, Score);
        end
        @(negedge Clk);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        checks++;
        if (q_I !== 1'b1 || Y !== 10'd479 || Score !== 16'd30 || HiScore !== 16'd30) begin
            failures++;
            $display("FAIL ack_idle got I=%b Y=%0d S=%0d H=%0d exp 1/479/30/30",
                     q_I, Y, Score, HiScore);
        end
    endtask

    task automatic test_second_game;
        do_start(10'd9);
        checks++;
        if (Y !== 10'd400 || Score !== 16'd0 || J !== 10'd9) begin
            failures++;
            $display("FAIL game2_start got Y=%0d S=%0d J=%0d exp 400/0/9", Y, Score, J);
        end
        repeat (5) do_tick(1'b0);
        checks++;
        if (Curr !== 10'd9 || Score !== 16'd9 || Y !== 10'd391) begin
            failures++;
            $display("FAIL game2_laststep got C=%0d S=%0d Y=%0d exp 9/9/391", Curr, Score, Y);
        end
        for (int k = 0; k < 80 && q_Done !== 1'b1; k++) do_tick(1'b0);
        checks++;
        if (q_Done !== 1'b1 || HiScore !== 16'd30 || Y !== 10'd479) begin
            failures++;
            $display("FAIL game2_hiscore got Done=%b H=%0d Y=%0d exp 1/30/479", q_Done, HiScore, Y);
        end
        @(negedge Clk);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
    endtask

    task automatic test_mid_reset;
        do_start(10'd0);
        checks++;
        if (J !== 10'd100) begin
            failures++;
            $display("FAIL jin_zero got J=%0d exp 100", J);
        end
        repeat (3) do_tick(1'b0);
        checks++;
        if (Curr !== 10'd6 || q_Up !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got C=%0d Up=%b exp 6/1", Curr, q_Up);
        end
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({q_I, q_Up, q_Down, q_Done} !== 4'b1000 || Y !== 10'd400 || Curr !== 10'd0 ||
            J !== 10'd100 || Score !== 16'd0 || HiScore !== 16'd0 || Scroll !== 1'b0) begin
            failures++;
            $display("FAIL midrst got st=%b Y=%0d C=%0d J=%0d S=%0d H=%0d Sc=%b",
                     {q_I, q_Up, q_Down, q_Done}, Y, Curr, J, Score, HiScore, Scroll);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        Tick  = 1'b0;
        Start = 1'b0;
        Ack   = 1'b0;
        Land  = 1'b0;
        Jin   = '0;
        test_reset();
        test_scroll();
        test_reset();
        test_jump();
        test_landing();
        test_death();
        test_second_game();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
